// File: rtl/qdr_rd_scheduler.sv
// qdr_rd_scheduler: read-side scheduler for the QDR packet store.
// Shares one memory read-address port among four replay queues, grants
// round-robin and issues up to BURST_MAX back-to-back read commands per
// grant. Owns the per-queue head pointers and a per-queue credit counter
// sized to that queue's return FIFO.
// Build option: define QDR_RD_STRICT_PRIO_EN to replace round-robin with
// fixed priority (q0 highest). The default build is round-robin.
//
// Command handshake: a command is accepted by the memory on any cycle in
// which the scheduler is issuing and mem_rd_full is low; while mem_rd_full
// is high the pending command is held and nothing is strobed. Each accepted
// command appears one cycle later as a single-cycle mem_ad_r_n low /
// rd_tag_vld high pulse with address {qid, head} and rd_tag_qid.
module qdr_rd_scheduler #(
  parameter int NUM_QUEUES     = 4,
  parameter int MEM_ADDR_WIDTH = 19,
  parameter int PTR_WIDTH      = MEM_ADDR_WIDTH - 2,
  parameter int CREDITS        = 16,
  parameter int CREDIT_WIDTH   = 5,
  parameter int BURST_MAX      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cal_done,
  input  logic [NUM_QUEUES-1:0]     q_enable,
  input  logic [PTR_WIDTH-1:0]      q0_addr_tail,
  input  logic [PTR_WIDTH-1:0]      q1_addr_tail,
  input  logic [PTR_WIDTH-1:0]      q2_addr_tail,
  input  logic [PTR_WIDTH-1:0]      q3_addr_tail,
  output logic [PTR_WIDTH-1:0]      q0_addr_head,
  output logic [PTR_WIDTH-1:0]      q1_addr_head,
  output logic [PTR_WIDTH-1:0]      q2_addr_head,
  output logic [PTR_WIDTH-1:0]      q3_addr_head,
  input  logic [NUM_QUEUES-1:0]     q_rd_done,
  input  logic                      mem_rd_full,
  output logic                      mem_ad_r_n,
  output logic [MEM_ADDR_WIDTH-1:0] mem_ad_rd,
  output logic                      rd_tag_vld,
  output logic [1:0]                rd_tag_qid,
  output logic [1:0]                dbg_state
);

  localparam int BCW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [NUM_QUEUES-1:0][PTR_WIDTH-1:0]    head_r;
  logic [NUM_QUEUES-1:0][PTR_WIDTH-1:0]    tail;
  logic [NUM_QUEUES-1:0][CREDIT_WIDTH-1:0] credit_r;
  logic [NUM_QUEUES-1:0]                   elig;
  logic [NUM_QUEUES-1:0]                   issue_vec;

  logic [1:0]     gnt_r, gnt_nx;
  logic [1:0]     rr_ptr, rr_nx;
  logic [BCW-1:0] burst_cnt;
  logic           burst_clr;
  logic           issue;
  logic           arb_any;
  logic [1:0]     arb_pick;
`ifndef QDR_RD_STRICT_PRIO_EN
  logic [1:0]     arb_idx;
`endif

  assign tail         = {q3_addr_tail, q2_addr_tail, q1_addr_tail, q0_addr_tail};
  assign q0_addr_head = head_r[0];
  assign q1_addr_head = head_r[1];
  assign q2_addr_head = head_r[2];
  assign q3_addr_head = head_r[3];
  assign dbg_state    = state;

  // Per-queue eligibility from the pre-increment head, so issue never passes tail.
  always_comb begin
    elig      = '0;
    issue_vec = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      elig[i]      = q_enable[i] && (head_r[i] != tail[i]) && (credit_r[i] != '0);
      issue_vec[i] = issue && (gnt_r == 2'(i));
    end
  end

`ifdef QDR_RD_STRICT_PRIO_EN
  // Fixed-priority pick: lowest-index eligible queue wins.
  always_comb begin
    arb_any  = |elig;
    arb_pick = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (elig[i]) arb_pick = 2'(i);
    end
  end
`else
  // Round-robin pick: first eligible queue at or after rr_ptr, cyclically.
  always_comb begin
    arb_any  = 1'b0;
    arb_pick = rr_ptr;
    arb_idx  = '0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      arb_idx = rr_ptr + 2'(k);
      if (!arb_any && elig[arb_idx]) begin
        arb_pick = arb_idx;
        arb_any  = 1'b1;
      end
    end
  end
`endif

  // Next-state logic: arbitration, burst issue and the cal_done abort path.
  always_comb begin
    state_nx  = state;
    gnt_nx    = gnt_r;
    rr_nx     = rr_ptr;
    burst_clr = 1'b0;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cal_done) state_nx = S_ARB;
      end
      S_ARB: begin
        if (!cal_done) begin
          state_nx = S_IDLE;
        end else if (arb_any) begin
          gnt_nx    = arb_pick;
          burst_clr = 1'b1;
          state_nx  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!cal_done) begin
          state_nx = S_IDLE;
        end else if (!elig[gnt_r]) begin
          rr_nx    = gnt_r + 2'd1;
          state_nx = S_ARB;
        end else if (!mem_rd_full) begin
          issue = 1'b1;
          if (burst_cnt == BCW'(BURST_MAX - 1)) begin
            rr_nx    = gnt_r + 2'd1;
            state_nx = S_ARB;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM state, grant, round-robin pointer and burst counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt_r     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state  <= state_nx;
      gnt_r  <= gnt_nx;
      rr_ptr <= rr_nx;
      if (burst_clr) burst_cnt <= '0;
      else if (issue) burst_cnt <= burst_cnt + BCW'(1);
    end
  end

  // Head pointers advance by one per issued command, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= '0;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (issue_vec[i]) head_r[i] <= head_r[i] + PTR_WIDTH'(1);
      end
    end
  end

  // Credits: issue takes one, a done pulse returns one (saturating at CREDITS).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_QUEUES; i++) credit_r[i] <= CREDIT_WIDTH'(CREDITS);
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (issue_vec[i] && !q_rd_done[i]) begin
          credit_r[i] <= credit_r[i] - CREDIT_WIDTH'(1);
        end else if (!issue_vec[i] && q_rd_done[i] &&
                     (credit_r[i] != CREDIT_WIDTH'(CREDITS))) begin
          credit_r[i] <= credit_r[i] + CREDIT_WIDTH'(1);
        end
      end
    end
  end

  // Registered command strobe, address and return-path tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ad_r_n <= 1'b1;
      mem_ad_rd  <= '0;
      rd_tag_vld <= 1'b0;
      rd_tag_qid <= '0;
    end else begin
      mem_ad_r_n <= !issue;
      rd_tag_vld <= issue;
      if (issue) begin
        mem_ad_rd  <= {gnt_r, head_r[gnt_r]};
        rd_tag_qid <= gnt_r;
      end
    end
  end

endmodule

// File: tb/tb_qdr_rd_scheduler.sv
// tb_qdr_rd_scheduler: directed bench for qdr_rd_scheduler. A negedge
// monitor records every command strobe; tasks compare the recorded stream
// against hand-built expected queues.
module tb_qdr_rd_scheduler;

  localparam int PW = 17;
  localparam int AW = 19;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cal_done = 1'b0;
  logic [3:0]    q_enable = 4'h0;
  logic [PW-1:0] t0 = '0, t1 = '0, t2 = '0, t3 = '0;
  logic [PW-1:0] h0, h1, h2, h3;
  logic [3:0]    man_done = 4'h0;
  logic [3:0]    auto_vec = 4'h0;
  logic          auto_done = 1'b0;
  logic [3:0]    q_rd_done;
  logic          mem_rd_full = 1'b0;
  logic          mem_ad_r_n;
  logic [AW-1:0] mem_ad_rd;
  logic          rd_tag_vld;
  logic [1:0]    rd_tag_qid;
  logic [1:0]    dbg_state;

  assign q_rd_done = auto_done ? auto_vec : man_done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  qdr_rd_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cal_done(cal_done), .q_enable(q_enable),
    .q0_addr_tail(t0), .q1_addr_tail(t1), .q2_addr_tail(t2), .q3_addr_tail(t3),
    .q0_addr_head(h0), .q1_addr_head(h1), .q2_addr_head(h2), .q3_addr_head(h3),
    .q_rd_done(q_rd_done), .mem_rd_full(mem_rd_full), .mem_ad_r_n(mem_ad_r_n),
    .mem_ad_rd(mem_ad_rd), .rd_tag_vld(rd_tag_vld), .rd_tag_qid(rd_tag_qid),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_addr[$];
  logic [1:0]    got_qid[$];
  logic          got_pair[$];
  int            got_cyc[$];
  int total = 0;
  int bad   = 0;

  // Monitor: record strobes and return a done pulse when auto_done is set.
  always @(negedge clk) begin
    auto_vec = 4'h0;
    if (rst_n && (!mem_ad_r_n || rd_tag_vld)) begin
      got_addr.push_back(mem_ad_rd);
      got_qid.push_back(rd_tag_qid);
      got_pair.push_back(rd_tag_vld && !mem_ad_r_n);
      got_cyc.push_back(cyc);
      if (!mem_ad_r_n) auto_vec[rd_tag_qid] = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_qid.delete();
    got_pair.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cal_done = 1'b0;
    q_enable = 4'h0;
    t0 = '0; t1 = '0; t2 = '0; t3 = '0;
    man_done = 4'h0;
    auto_done = 1'b0;
    mem_rd_full = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_got();
  endtask

  task automatic start_run();
    q_enable = 4'hF;
    cal_done = 1'b1;
    tick(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(1);
    total++; if (mem_ad_r_n !== 1'b1) begin bad++; $display("FAIL reset_r_n got=%b exp=1", mem_ad_r_n); end
    total++; if (rd_tag_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", rd_tag_vld); end
    total++; if (mem_ad_rd !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_ad_rd); end
    total++; if (rd_tag_qid !== 2'd0) begin bad++; $display("FAIL reset_qid got=%0d exp=0", rd_tag_qid); end
    total++; if ({h3, h2, h1, h0} !== '0) begin bad++; $display("FAIL reset_heads got=%h exp=0", {h3, h2, h1, h0}); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    rst_n = 1'b1;
    tick(3);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL idle_wait_cal got=%0d exp=%0d", dbg_state, ST_IDLE); end
    cal_done = 1'b1;
    tick(1);
    total++; if (dbg_state !== ST_ARB) begin bad++; $display("FAIL idle_to_arb got=%0d exp=%0d", dbg_state, ST_ARB); end
  endtask

  task automatic test_single();
    logic [AW-1:0] g;
    int c0;
    do_reset();
    start_run();
    c0 = cyc;
    t1 = 17'd3;
    tick(10);
    for (int k = 0; k < 3; k++) exp_q.push_back(19'h20000 + 19'(k));
    total++; if (got_addr.size() != 3) begin bad++; $display("FAIL single_count got=%0d exp=3", got_addr.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_addr.size()) ? got_addr[k] : 'x;
      total++; if (g !== exp_q[k]) begin bad++; $display("FAIL single_addr[%0d] got=%h exp=%h", k, g, exp_q[k]); end
      if (k < got_addr.size()) begin
        total++; if (got_qid[k] !== 2'd1) begin bad++; $display("FAIL single_qid[%0d] got=%0d exp=1", k, got_qid[k]); end
        total++; if (got_pair[k] !== 1'b1) begin bad++; $display("FAIL single_tag_pair[%0d] got=%b exp=1", k, got_pair[k]); end
        total++; if (got_cyc[k] != c0 + 2 + k) begin bad++; $display("FAIL single_timing[%0d] got=%0d exp=%0d", k, got_cyc[k], c0 + 2 + k); end
      end
    end
    total++; if (h1 !== 17'd3) begin bad++; $display("FAIL single_head got=%h exp=3", h1); end
    total++; if (dbg_state !== ST_ARB) begin bad++; $display("FAIL single_back_arb got=%0d exp=%0d", dbg_state, ST_ARB); end
  endtask

  task automatic test_fairness();
    logic [AW-1:0] g;
    int rem[4];
    int n;
    do_reset();
    auto_done = 1'b1;
    start_run();
    t0 = 17'd20; t1 = 17'd20; t2 = 17'd20; t3 = 17'd20;
    tick(200);
    for (int q = 0; q < 4; q++) rem[q] = 20;
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
      for (int q = 0; q < 4; q++) begin
        n = (rem[q] > 8) ? 8 : rem[q];
        for (int k = 0; k < n; k++) exp_q.push_back({2'(q), 17'(20 - rem[q] + k)});
        rem[q] -= n;
      end
    end
    total++; if (got_addr.size() != exp_q.size()) begin bad++; $display("FAIL fair_count got=%0d exp=%0d", got_addr.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_addr.size()) ? got_addr[k] : 'x;
      total++; if (g !== exp_q[k]) begin bad++; $display("FAIL fair_addr[%0d] got=%h exp=%h", k, g, exp_q[k]); end
    end
    total++; if ({h3, h2, h1, h0} !== {4{17'd20}}) begin bad++; $display("FAIL fair_heads got=%h/%h/%h/%h exp=20 each", h0, h1, h2, h3); end
    auto_done = 1'b0;
  endtask

  task automatic test_credit_stall();
    logic [AW-1:0] g;
    do_reset();
    start_run();
    // Done pulses while credit is full must be ignored.
    for (int k = 0; k < 3; k++) begin
      man_done = 4'b0100; tick(1);
      man_done = 4'b0000; tick(1);
    end
    t2 = 17'd30;
    tick(60);
    for (int k = 0; k < 16; k++) exp_q.push_back(19'h40000 + 19'(k));
    total++; if (got_addr.size() != 16) begin bad++; $display("FAIL credit_count got=%0d exp=16", got_addr.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_addr.size()) ? got_addr[k] : 'x;
      total++; if (g !== exp_q[k]) begin bad++; $display("FAIL credit_addr[%0d] got=%h exp=%h", k, g, exp_q[k]); end
    end
    total++; if (dbg_state !== ST_ARB) begin bad++; $display("FAIL credit_idle_state got=%0d exp=%0d", dbg_state, ST_ARB); end
    clear_got();
    for (int k = 0; k < 2; k++) begin
      man_done = 4'b0100; tick(1);
      man_done = 4'b0000; tick(1);
    end
    tick(20);
    exp_q.push_back(19'h40010);
    exp_q.push_back(19'h40011);
    total++; if (got_addr.size() != 2) begin bad++; $display("FAIL credit_refill_count got=%0d exp=2", got_addr.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_addr.size()) ? got_addr[k] : 'x;
      total++; if (g !== exp_q[k]) begin bad++; $display("FAIL credit_refill_addr[%0d] got=%h exp=%h", k, g, exp_q[k]); end
    end
    total++; if (h2 !== 17'd18) begin bad++; $display("FAIL credit_head got=%h exp=12", h2); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] g;
    do_reset();
    start_run();
    t3 = 17'd8;
    tick(4);
    total++; if (got_addr.size() != 3) begin bad++; $display("FAIL bp_pre_count got=%0d exp=3", got_addr.size()); end
    mem_rd_full = 1'b1;
    tick(5);
    total++; if (got_addr.size() != 3) begin bad++; $display("FAIL bp_stall_strobe got=%0d exp=3", got_addr.size()); end
    mem_rd_full = 1'b0;
    tick(15);
    for (int k = 0; k < 8; k++) exp_q.push_back(19'h60000 + 19'(k));
    total++; if (got_addr.size() != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", got_addr.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_addr.size()) ? got_addr[k] : 'x;
      total++; if (g !== exp_q[k]) begin bad++; $display("FAIL bp_addr[%0d] got=%h exp=%h", k, g, exp_q[k]); end
    end
    total++; if (h3 !== 17'd8) begin bad++; $display("FAIL bp_head got=%h exp=8", h3); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] g;
    do_reset();
    force dut.head_r = {17'd0, 17'd0, 17'd0, 17'h1FFFE};
    tick(1);
    release dut.head_r;
    tick(1);
    total++; if (h0 !== 17'h1FFFE) begin bad++; $display("FAIL wrap_preload got=%h exp=1fffe", h0); end
    t0 = 17'h00001;
    start_run();
    tick(15);
    exp_q.push_back(19'h1FFFE);
    exp_q.push_back(19'h1FFFF);
    exp_q.push_back(19'h00000);
    total++; if (got_addr.size() != 3) begin bad++; $display("FAIL wrap_count got=%0d exp=3", got_addr.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_addr.size()) ? got_addr[k] : 'x;
      total++; if (g !== exp_q[k]) begin bad++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", k, g, exp_q[k]); end
    end
    total++; if (h0 !== 17'h00001) begin bad++; $display("FAIL wrap_head got=%h exp=1", h0); end
  endtask

  task automatic test_async_reset();
    logic [AW-1:0] g;
    do_reset();
    start_run();
    t1 = 17'd10;
    tick(3);
    total++; if (mem_ad_r_n !== 1'b0) begin bad++; $display("FAIL areset_mid_burst got=%b exp=0", mem_ad_r_n); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (mem_ad_r_n !== 1'b1) begin bad++; $display("FAIL areset_r_n got=%b exp=1", mem_ad_r_n); end
    total++; if (rd_tag_vld !== 1'b0) begin bad++; $display("FAIL areset_vld got=%b exp=0", rd_tag_vld); end
    total++; if (h1 !== '0) begin bad++; $display("FAIL areset_head got=%h exp=0", h1); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL areset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    tick(1);
    rst_n = 1'b1;
    clear_got();
    t1 = 17'd20;
    tick(60);
    for (int k = 0; k < 16; k++) exp_q.push_back(19'h20000 + 19'(k));
    total++; if (got_addr.size() != 16) begin bad++; $display("FAIL areset_credit_count got=%0d exp=16", got_addr.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_addr.size()) ? got_addr[k] : 'x;
      total++; if (g !== exp_q[k]) begin bad++; $display("FAIL areset_addr[%0d] got=%h exp=%h", k, g, exp_q[k]); end
    end
  endtask

  task automatic test_priority();
    logic [AW-1:0] g;
    do_reset();
    start_run();
    t0 = 17'd12;
    t3 = 17'd5;
    tick(60);
    for (int k = 0; k < 8; k++) exp_q.push_back(19'h00000 + 19'(k));
`ifdef QDR_RD_STRICT_PRIO_EN
    for (int k = 8; k < 12; k++) exp_q.push_back(19'h00000 + 19'(k));
    for (int k = 0; k < 5; k++) exp_q.push_back(19'h60000 + 19'(k));
`else
    for (int k = 0; k < 5; k++) exp_q.push_back(19'h60000 + 19'(k));
    for (int k = 8; k < 12; k++) exp_q.push_back(19'h00000 + 19'(k));
`endif
    total++; if (got_addr.size() != 17) begin bad++; $display("FAIL prio_count got=%0d exp=17", got_addr.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_addr.size()) ? got_addr[k] : 'x;
      total++; if (g !== exp_q[k]) begin bad++; $display("FAIL prio_addr[%0d] got=%h exp=%h", k, g, exp_q[k]); end
    end
    total++; if ({h3, h0} !== {17'd5, 17'd12}) begin bad++; $display("FAIL prio_heads got=%h/%h exp=c/5", h0, h3); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_credit_stall();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
